// File: rtl/execute_mem_stage.sv
// Execute / memory stage: runs the registered ALU op, issues data-memory
// accesses over a req/ack handshake, and drives the writeback register.
// Upstream ID/EX is stalled while an access is outstanding.
module execute_mem_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemToRegE,
  input  logic [1:0]        aluFuncE,
  input  logic [DATA_W-1:0] srcDataE1,
  input  logic [DATA_W-1:0] srcDataE2,
  input  logic [REG_W-1:0]  destAddE,
  output logic              stallE,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWdata,
  input  logic [DATA_W-1:0] memRdata,
  input  logic              memAck,
  output logic              validW,
  output logic              RegWriteW,
  output logic [REG_W-1:0]  destAddW,
  output logic [DATA_W-1:0] resultW,
  output logic              memErr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] result;
  } wb_t;

  // Outstanding-access bookkeeping
  typedef struct packed {
    logic             store;
    logic             regwrite;
    logic [REG_W-1:0] dest;
  } pend_t;

  state_t            state_q, state_nxt;
  mem_req_t          mreq_q, mreq_nxt;
  wb_t               wb_q, wb_nxt;
  pend_t             pend_q, pend_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              err_q, err_nxt;
  logic [DATA_W-1:0] alu;
  logic              is_store, is_load, ack, timeout;

  // ALU: wrap-around add/sub, bitwise and/or
  always_comb begin
    case (aluFuncE)
      2'b00:   alu = srcDataE1 + srcDataE2;
      2'b01:   alu = srcDataE1 - srcDataE2;
      2'b10:   alu = srcDataE1 & srcDataE2;
      default: alu = srcDataE1 | srcDataE2;
    endcase
  end

  // Acks only count while a request is actually on the bus
  assign is_store = validE & MemWriteE;
  assign is_load  = validE & MemToRegE & ~MemWriteE;
  assign ack      = memAck & mreq_q.req;
  assign timeout  = (cnt_q == CNT_LAST) & ~ack;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:     if (is_store | is_load) state_nxt = MEM_WAIT;
      MEM_WAIT: if (ack | timeout)      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values; registered below
  always_comb begin
    mreq_nxt        = mreq_q;
    wb_nxt          = wb_q;
    wb_nxt.valid    = 1'b0;
    wb_nxt.regwrite = 1'b0;
    pend_nxt        = pend_q;
    cnt_nxt         = cnt_q;
    err_nxt         = err_q;
    case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (is_store) begin
          mreq_nxt = '{req: 1'b1, we: 1'b1, addr: srcDataE1[ADDR_W-1:0], wdata: srcDataE2};
          pend_nxt = '{store: 1'b1, regwrite: RegWriteE, dest: destAddE};
        end else if (is_load) begin
          mreq_nxt = '{req: 1'b1, we: 1'b0, addr: alu[ADDR_W-1:0], wdata: srcDataE2};
          pend_nxt = '{store: 1'b0, regwrite: RegWriteE, dest: destAddE};
        end else if (validE) begin
          wb_nxt = '{valid: 1'b1, regwrite: RegWriteE, dest: destAddE, result: alu};
        end
      end
      MEM_WAIT: begin
        if (ack) begin
          mreq_nxt.req = 1'b0;
          wb_nxt.valid = 1'b1;
          wb_nxt.dest  = pend_q.dest;
          if (!pend_q.store) begin
            wb_nxt.result   = memRdata;
            wb_nxt.regwrite = pend_q.regwrite;
          end
          cnt_nxt = '0;
        end else if (timeout) begin
          // Abort: retire as a non-writing instruction and flag the error
          mreq_nxt.req = 1'b0;
          wb_nxt.valid = 1'b1;
          wb_nxt.dest  = pend_q.dest;
          err_nxt      = 1'b1;
          cnt_nxt      = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      mreq_q <= '0;
      wb_q   <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mreq_q <= mreq_nxt;
      wb_q   <= wb_nxt;
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
      err_q  <= err_nxt;
    end
  end

  assign stallE    = (state_q == MEM_WAIT);
  assign memReq    = mreq_q.req;
  assign memWe     = mreq_q.we;
  assign memAddr   = mreq_q.addr;
  assign memWdata  = mreq_q.wdata;
  assign validW    = wb_q.valid;
  assign RegWriteW = wb_q.regwrite;
  assign destAddW  = wb_q.dest;
  assign resultW   = wb_q.result;
  assign memErr    = err_q;

endmodule

// File: tb/tb_execute_mem_stage.sv
// Bench for execute_mem_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_execute_mem_stage;
  localparam int DW = 16, AW = 12, RW = 4, TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          validE, RegWriteE, MemWriteE, MemToRegE;
  logic [1:0]    aluFuncE;
  logic [DW-1:0] srcDataE1, srcDataE2, memRdata, memWdata, resultW;
  logic [RW-1:0] destAddE, destAddW;
  logic [AW-1:0] memAddr;
  logic          stallE, memReq, memWe, memAck, validW, RegWriteW, memErr;

  execute_mem_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .validE(validE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .MemToRegE(MemToRegE), .aluFuncE(aluFuncE),
    .srcDataE1(srcDataE1), .srcDataE2(srcDataE2), .destAddE(destAddE),
    .stallE(stallE), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWdata(memWdata), .memRdata(memRdata), .memAck(memAck),
    .validW(validW), .RegWriteW(RegWriteW), .destAddW(destAddW),
    .resultW(resultW), .memErr(memErr));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
    int x;
    case (f)
      2'd0:    x = (int'(a) + int'(b)) % 65536;
      2'd1:    x = (int'(a) - int'(b) + 65536) % 65536;
      2'd2:    x = int'(a & b);
      default: x = int'(a | b);
    endcase
    return 16'(x);
  endfunction

  // ---------------- behavioural model ----------------
  // A memory access is "in flight" from the cycle it is issued until ack or
  // abort; expectations are what the outputs must read after each edge.
  bit            armed = 0;
  bit            busy = 0, p_store = 0, p_rw = 0;
  int            waited = 0;
  logic [RW-1:0] p_dest = '0;
  logic          e_req = 0, e_we = 0, e_vw = 0, e_rww = 0, e_err = 0, e_full = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_res = '0;
  logic [RW-1:0] e_dest = '0;

  always @(negedge clk) begin
    logic [DW-1:0] a;
    if (armed) begin
      chk("stallE", stallE, busy);
      chk("memReq", memReq, e_req);
      chk("memErr", memErr, e_err);
      chk("validW", validW, e_vw);
      chk("RegWriteW", RegWriteW, e_rww);
      if (e_req) begin
        chk("memWe", memWe, e_we);
        chk("memAddr", memAddr, e_addr);
        if (e_we) chk("memWdata", memWdata, e_wdata);
      end
      if (e_vw && e_full) begin
        chk("destAddW", destAddW, e_dest);
        chk("resultW", resultW, e_res);
      end
    end
    // advance model with the inputs the next edge will sample
    if (!reset) begin
      armed = 1; busy = 0; waited = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
      e_vw = 0; e_rww = 0; e_err = 0; e_res = '0; e_dest = '0; e_full = 0;
    end else begin
      e_vw = 0; e_rww = 0; e_full = 0;
      if (!busy) begin
        if (validE) begin
          a = alu_f(aluFuncE, srcDataE1, srcDataE2);
          if (MemWriteE || MemToRegE) begin
            busy = 1; waited = 0; p_store = MemWriteE; p_rw = RegWriteE; p_dest = destAddE;
            e_req = 1; e_we = MemWriteE;
            e_addr = MemWriteE ? srcDataE1[AW-1:0] : a[AW-1:0];
            e_wdata = srcDataE2;
          end else begin
            e_vw = 1; e_full = 1; e_rww = RegWriteE; e_dest = destAddE; e_res = a;
          end
        end
      end else if (memAck) begin
        busy = 0; e_req = 0; e_vw = 1; e_full = 1; e_dest = p_dest;
        if (!p_store) begin e_res = memRdata; e_rww = p_rw; end
      end else if (waited == TO - 1) begin
        busy = 0; e_req = 0; e_err = 1; e_vw = 1;
      end else begin
        waited++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic v, input logic rw, input logic mw, input logic mr,
                    input logic [1:0] f, input logic [15:0] a, input logic [15:0] b,
                    input logic [3:0] d);
    validE = v; RegWriteE = rw; MemWriteE = mw; MemToRegE = mr;
    aluFuncE = f; srcDataE1 = a; srcDataE2 = b; destAddE = d;
  endtask

  task automatic idle();
    op(0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 4'h0);
  endtask

  initial begin
    reset = 0; memAck = 0; memRdata = '0; idle();
    cycle(); cycle();
    chk("rst memReq", memReq, 0); chk("rst validW", validW, 0);
    chk("rst memErr", memErr, 0); chk("rst stallE", stallE, 0);
    reset = 1;

    // ADD with wrap
    op(1, 1, 0, 0, 2'd0, 16'hFFFF, 16'h0002, 4'd3); cycle();
    chk("add res", resultW, 16'h0001); chk("add vw", validW, 1);
    chk("add dest", destAddW, 3); chk("add rw", RegWriteW, 1); chk("add stall", stallE, 0);

    // back-to-back SUB / AND / OR
    op(1, 1, 0, 0, 2'd1, 16'h0000, 16'h0001, 4'd1); cycle();
    chk("sub res", resultW, 16'hFFFF);
    op(1, 1, 0, 0, 2'd2, 16'hF0F0, 16'h0FF0, 4'd2); cycle();
    chk("and res", resultW, 16'h00F0); chk("and vw", validW, 1);
    op(1, 1, 0, 0, 2'd3, 16'h1200, 16'h0034, 4'd4); cycle();
    chk("or res", resultW, 16'h1234); chk("or vw", validW, 1);
    idle(); cycle();
    chk("bubble vw", validW, 0);

    // load, ack in third wait cycle
    op(1, 1, 0, 1, 2'd0, 16'h0100, 16'h0023, 4'd5); cycle();
    chk("ld req", memReq, 1); chk("ld we", memWe, 0);
    chk("ld addr", memAddr, 12'h123); chk("ld stall", stallE, 1);
    idle();
    repeat (2) begin
      cycle();
      chk("ld hold addr", memAddr, 12'h123); chk("ld hold req", memReq, 1);
      chk("ld hold stall", stallE, 1);
    end
    memAck = 1; memRdata = 16'hBEEF; cycle(); memAck = 0;
    chk("ld res", resultW, 16'hBEEF); chk("ld vw", validW, 1);
    chk("ld rw", RegWriteW, 1); chk("ld dest", destAddW, 5);
    chk("ld req off", memReq, 0); chk("ld stall off", stallE, 0);

    // store, ack after one cycle, then an ALU op
    op(1, 1, 1, 0, 2'd0, 16'h0ABC, 16'h5A5A, 4'd7); cycle();
    chk("st addr", memAddr, 12'hABC); chk("st wdata", memWdata, 16'h5A5A); chk("st we", memWe, 1);
    idle(); memAck = 1; cycle(); memAck = 0;
    chk("st vw", validW, 1); chk("st rw", RegWriteW, 0); chk("st res hold", resultW, 16'hBEEF);
    op(1, 1, 0, 0, 2'd0, 16'h0001, 16'h0002, 4'd2); cycle(); idle();
    chk("post st res", resultW, 16'h0003); chk("post st vw", validW, 1);

    // load timeout
    op(1, 1, 0, 1, 2'd0, 16'h0000, 16'h0010, 4'd4); cycle(); idle();
    repeat (TO - 1) cycle();
    chk("to still req", memReq, 1); chk("to no vw yet", validW, 0);
    cycle();
    chk("to req drop", memReq, 0); chk("to err", memErr, 1);
    chk("to vw", validW, 1); chk("to rw", RegWriteW, 0); chk("to stall", stallE, 0);
    memAck = 1; memRdata = 16'h1111; cycle(); memAck = 0;
    chk("late ack vw", validW, 0); chk("late ack err", memErr, 1); chk("late ack req", memReq, 0);
    cycle(); chk("err sticky", memErr, 1);

    // reset while waiting
    op(1, 1, 0, 1, 2'd0, 16'h0000, 16'h0040, 4'd6); cycle(); idle(); cycle();
    reset = 0; cycle(); reset = 1;
    chk("mrst req", memReq, 0); chk("mrst stall", stallE, 0);
    chk("mrst vw", validW, 0); chk("mrst err", memErr, 0);
    op(1, 1, 0, 0, 2'd0, 16'h0005, 16'h0006, 4'd1); cycle(); idle();
    chk("mrst add res", resultW, 16'h000B); chk("mrst add vw", validW, 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) != 0);
      validE    = ($urandom_range(0, 2) != 0);
      RegWriteE = 1'($urandom);
      MemWriteE = ($urandom_range(0, 3) == 0);
      MemToRegE = ($urandom_range(0, 2) == 0);
      aluFuncE  = 2'($urandom);
      srcDataE1 = 16'($urandom);
      srcDataE2 = 16'($urandom);
      destAddE  = 4'($urandom);
      memRdata  = 16'($urandom);
      memAck    = memReq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      cycle();
    end
    reset = 1; idle(); memAck = 0;
    cycle(); cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
